// File: rtl/pixel_pkg.sv
// Shared pixel-path definitions for the UART writer, the frame reader and the TFT controller.
package pixel_pkg;

    localparam int PIX_ADDR_W   = 16;
    localparam int PIX_DATA_W   = 16;
    localparam int PIX_H_ACTIVE = 256;
    localparam int PIX_V_ACTIVE = 256;

    typedef struct packed {
        logic [PIX_DATA_W-1:0] data;
        logic                  sof;
        logic                  eol;
    } pix_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_e;

endpackage

// File: rtl/ram_frame_reader_if.sv
// RAM port-B read bus plus the outgoing pixel stream of the frame reader.
interface ram_frame_reader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              enb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] doutb;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_sof;
    logic              m_eol;

    modport master (
        output enb, addrb, m_data, m_valid, m_sof, m_eol,
        input  doutb, m_ready
    );

    modport slave (
        input  enb, addrb, m_data, m_valid, m_sof, m_eol,
        output doutb, m_ready
    );
endinterface

// File: rtl/ram_frame_reader_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; the head word is visible whenever not empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/ram_frame_reader.sv
// Streams one frame of pixels from RAM port B as a valid/ready beat stream with sof/eol flags,
// issuing reads only while FIFO slots are free so that RAM latency and sink stalls are absorbed.
module ram_frame_reader
    import pixel_pkg::*;
#(
    parameter int ADDR_W     = PIX_ADDR_W,
    parameter int DATA_W     = PIX_DATA_W,
    parameter int H_ACTIVE   = PIX_H_ACTIVE,
    parameter int V_ACTIVE   = PIX_V_ACTIVE,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic               busy,
    output logic               frame_done,
    ram_frame_reader_if.master bus
);
    localparam int TOTAL  = H_ACTIVE * V_ACTIVE;
    localparam int CNT_W  = ADDR_W + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CR_W   = FCNT_W + 1;
    localparam int COL_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(TOTAL - 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(H_ACTIVE - 1);
    localparam logic [CR_W-1:0]  DEPTH_CR  = CR_W'(FIFO_DEPTH);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic                enb_q, enb_d;
    logic [ADDR_W-1:0]   addrb_q, addrb_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic [RD_LAT-1:0]   pipe_q, pipe_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                first_q, first_d;

    logic                push, pop;
    logic [DATA_W+1:0]   fifo_wdata, fifo_rdata;
    logic [FCNT_W-1:0]   fifo_count;
    logic                fifo_empty;
    logic [CR_W-1:0]     credits;
    logic                issue_ok, drained;

    assign push       = pipe_q[RD_LAT-1];
    assign pop        = !fifo_empty && bus.m_ready;
    assign fifo_wdata = {bus.doutb, first_q, (col_q == LAST_COL)};

    // Slots committed for the next cycle: stored beats plus reads in flight, less the beat leaving now.
    always_comb begin
        credits = CR_W'(fifo_count) + CR_W'(enb_q) - CR_W'(pop);
        for (int i = 0; i < RD_LAT; i++) begin
            credits = credits + CR_W'(pipe_q[i]);
        end
    end

    always_comb begin
        issue_ok     = (credits < DEPTH_CR);
        drained      = !enb_q && (pipe_q == '0) &&
                       ((fifo_count == '0) || ((fifo_count == FCNT_W'(1)) && pop));
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        enb_d        = 1'b0;
        addrb_d      = addrb_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        pipe_d       = pipe_q << 1;
        pipe_d[0]    = enb_q;
        col_d        = col_q;
        first_d      = first_q;

        if (push) begin
            col_d   = (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
            first_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d      = 1'b1;
                    enb_d       = 1'b1;
                    addrb_d     = '0;
                    issue_cnt_d = CNT_W'(1);
                    col_d       = '0;
                    first_d     = 1'b1;
                    state_d     = (LAST_ADDR == '0) ? DRAIN : READ;
                end
            end
            READ: begin
                if (issue_ok) begin
                    enb_d       = 1'b1;
                    addrb_d     = issue_cnt_q[ADDR_W-1:0];
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    if (issue_cnt_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drained) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            issue_cnt_q  <= '0;
            enb_q        <= 1'b0;
            addrb_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            pipe_q       <= '0;
            col_q        <= '0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            enb_q        <= enb_d;
            addrb_q      <= addrb_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            pipe_q       <= pipe_d;
            col_q        <= col_d;
            first_q      <= first_d;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 2),
        .CNT_W (FCNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // Outputs read as zero whenever no beat is held, including straight out of reset.
    assign bus.enb     = enb_q;
    assign bus.addrb   = addrb_q;
    assign bus.m_valid = !fifo_empty;
    assign bus.m_data  = fifo_empty ? '0 : fifo_rdata[DATA_W+1:2];
    assign bus.m_sof   = !fifo_empty && fifo_rdata[1];
    assign bus.m_eol   = !fifo_empty && fifo_rdata[0];
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ram_frame_reader.sv
// Bench for ram_frame_reader: a 4x2 RD_LAT=1 instance under varied sink behaviour and a
// full 256x256 RD_LAT=2 instance, both scored against an address-order pixel model.
module tb_ram_frame_reader;
    import pixel_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_s [2];
    logic start_s [2];
    logic ready_s [2];
    logic busy_s  [2];
    logic done_s  [2];
    int   gcyc = 0;

    always @(posedge clk) gcyc++;

    ram_frame_reader_if #(.ADDR_W(16), .DATA_W(16)) bus_a ();
    ram_frame_reader_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();

    assign bus_a.m_ready = ready_s[0];
    assign bus_b.m_ready = ready_s[1];

    ram_frame_reader #(
        .ADDR_W(16), .DATA_W(16), .H_ACTIVE(4), .V_ACTIVE(2), .RD_LAT(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .reset_n(rst_n_s[0]), .start(start_s[0]),
        .busy(busy_s[0]), .frame_done(done_s[0]), .bus(bus_a)
    );

    ram_frame_reader #(
        .ADDR_W(16), .DATA_W(16), .H_ACTIVE(256), .V_ACTIVE(256), .RD_LAT(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .reset_n(rst_n_s[1]), .start(start_s[1]),
        .busy(busy_s[1]), .frame_done(done_s[1]), .bus(bus_b)
    );

    // RAM models: A returns A000+addr one cycle after issue, B returns addr two cycles after.
    logic [15:0] rd1_b = '0;
    always @(posedge clk) begin
        if (bus_a.enb) bus_a.doutb <= 16'hA000 + bus_a.addrb;
    end
    always @(posedge clk) begin
        if (bus_b.enb) rd1_b <= bus_b.addrb;
        bus_b.doutb <= rd1_b;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int h_of(input int d);   return (d == 0) ? 4 : 256; endfunction
    function automatic int v_of(input int d);   return (d == 0) ? 2 : 256; endfunction
    function automatic int lat_of(input int d); return (d == 0) ? 1 : 2;   endfunction

    function automatic pix_beat_t exp_beat(input int d, input int idx);
        pix_beat_t   b;
        logic [15:0] a16;
        a16    = 16'(idx);
        b.data = (d == 0) ? 16'hA000 + a16 : a16;
        b.sof  = (idx == 0);
        b.eol  = ((idx % h_of(d)) == h_of(d) - 1);
        return b;
    endfunction

    bit          mon_en      [2];
    int          px          [2];
    int          enb_cnt     [2];
    int          done_cnt    [2];
    int          run_len     [2];
    int          max_run     [2];
    int          eol_cnt     [2];
    int          first_valid [2];
    int          start_cyc   [2];
    logic        prev_hold   [2];
    pix_beat_t   prev_beat   [2];
    logic [15:0] last_data   [2];
    logic [15:0] last_addr   [2];

    task automatic mon_step(input int d, input logic enb, input logic [15:0] addrb,
                            input logic valid, input logic ready, input logic [15:0] data,
                            input logic sof, input logic eol, input logic done);
        pix_beat_t obs;
        int        total;
        if (!mon_en[d]) return;
        total    = h_of(d) * v_of(d);
        obs.data = data;
        obs.sof  = sof;
        obs.eol  = eol;
        if (prev_hold[d]) check("hold_stable", 64'(obs), 64'(prev_beat[d]));
        if (enb) begin
            check("addrb", 64'(addrb), 64'(enb_cnt[d]));
            last_addr[d] = addrb;
            enb_cnt[d]++;
            run_len[d]++;
            if (run_len[d] > max_run[d]) max_run[d] = run_len[d];
        end else begin
            run_len[d] = 0;
        end
        if (valid && first_valid[d] < 0) first_valid[d] = gcyc;
        if (valid && ready) begin
            if (px[d] >= total) check("px_overrun", 64'(px[d]), 64'(total - 1));
            else check("pixel", 64'(obs), 64'(exp_beat(d, px[d])));
            if (eol) eol_cnt[d]++;
            last_data[d] = data;
            px[d]++;
        end
        prev_hold[d] = valid && !ready;
        prev_beat[d] = obs;
        if (done) done_cnt[d]++;
    endtask

    always @(negedge clk) mon_step(0, bus_a.enb, bus_a.addrb, bus_a.m_valid, bus_a.m_ready,
                                   bus_a.m_data, bus_a.m_sof, bus_a.m_eol, done_s[0]);
    always @(negedge clk) mon_step(1, bus_b.enb, bus_b.addrb, bus_b.m_valid, bus_b.m_ready,
                                   bus_b.m_data, bus_b.m_sof, bus_b.m_eol, done_s[1]);

    function automatic logic [63:0] outs_a();
        return 64'({bus_a.enb, bus_a.addrb, bus_a.m_valid, bus_a.m_data, bus_a.m_sof,
                    bus_a.m_eol, busy_s[0], done_s[0]});
    endfunction

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            1:       return (k > 20);
            2:       return (k % 2 == 1);
            3:       return ($urandom_range(0, 3) != 0);
            default: return 1'b1;
        endcase
    endfunction

    // mode: 0 ready=1, 1 stall 20 cycles, 2 toggle, 3 random; rst_px>0 resets after that many pixels
    task automatic run_frame(input int d, input int mode, input bit dup_start, input int rst_px);
        int total, k, budget;
        bit aborted;
        total   = h_of(d) * v_of(d);
        budget  = (d == 0) ? 300 : 70000;
        aborted = 1'b0;
        px[d] = 0; enb_cnt[d] = 0; done_cnt[d] = 0; run_len[d] = 0; max_run[d] = 0;
        eol_cnt[d] = 0; first_valid[d] = -1; prev_hold[d] = 1'b0;
        mon_en[d] = 1'b1;
        @(posedge clk); #1;
        start_cyc[d] = gcyc;
        start_s[d]   = 1'b1;
        ready_s[d]   = ready_for(mode, 0);
        k = 0;
        while (done_cnt[d] == 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
            start_s[d] = dup_start && (k == 3);
            ready_s[d] = ready_for(mode, k);
            if (k == 1) check("busy_rise", 64'(busy_s[d]), 64'd1);
            if (mode == 1 && k == 20) begin
                check("credit_stall", 64'(enb_cnt[d]), 64'd4);
                check("hold_data", 64'(bus_a.m_data), 64'(exp_beat(0, 0).data));
            end
            if (rst_px > 0 && px[d] >= rst_px) begin
                #2;
                rst_n_s[d] = 1'b0;
                #1;
                check("rst_async_outs", outs_a(), 64'd0);
                repeat (3) @(posedge clk);
                #1;
                check("rst_no_done", 64'(done_cnt[d]), 64'd0);
                check("rst_px_count", 64'(px[d]), 64'(rst_px));
                mon_en[d]  = 1'b0;
                rst_n_s[d] = 1'b1;
                aborted    = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            if (done_cnt[d] == 0) check("frame_done_seen", 64'(done_cnt[d]), 64'd1);
            start_s[d] = 1'b0;
            ready_s[d] = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            check("px_total", 64'(px[d]), 64'(total));
            check("issue_total", 64'(enb_cnt[d]), 64'(total));
            check("done_once", 64'(done_cnt[d]), 64'd1);
            check("busy_end", 64'(busy_s[d]), 64'd0);
            check("eol_total", 64'(eol_cnt[d]), 64'(v_of(d)));
            check("last_data", 64'(last_data[d]), 64'(exp_beat(d, total - 1).data));
            check("last_addrb", 64'(last_addr[d]), 64'(total - 1));
            if (mode == 0) begin
                check("first_latency", 64'(first_valid[d] - start_cyc[d]), 64'(2 + lat_of(d)));
                check("issue_run", 64'(max_run[d]), 64'(total));
            end
            mon_en[d] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n_s[i] = 1'b0; start_s[i] = 1'b0; ready_s[i] = 1'b1; mon_en[i] = 1'b0;
            prev_hold[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs_a", outs_a(), 64'd0);
        check("reset_outs_b", 64'({bus_b.enb, bus_b.addrb, bus_b.m_valid, bus_b.m_data,
                                   bus_b.m_sof, bus_b.m_eol, busy_s[1], done_s[1]}), 64'd0);
        rst_n_s[0] = 1'b1;
        rst_n_s[1] = 1'b1;
        while (gcyc < 9) @(posedge clk);

        run_frame(0, 0, 1'b0, 0);
        run_frame(0, 1, 1'b0, 0);
        run_frame(0, 2, 1'b0, 0);
        run_frame(0, 0, 1'b1, 0);
        run_frame(0, 0, 1'b0, 0);
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            run_frame(0, 3, ($urandom_range(0, 1) == 1), 0);
        end
        run_frame(0, 0, 1'b0, 3);
        repeat (2) @(posedge clk);
        run_frame(0, 0, 1'b0, 0);
        run_frame(1, 0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
